// File: rtl/bconv_seq_ctrl.sv
// Sequencer for a chain of K 1-bit binary-convolution PEs: loads the kernel weights, streams each
// valid-convolution window through the chain, and writes the majority-vote result per output pixel.
module bconv_seq_ctrl #(
    parameter int KW     = 3,
    parameter int IMG_W  = 16,
    parameter int ADDR_W = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   wmem_addr,
    input  logic                wmem_rd_data,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_rd_data,
    output logic [KW*KW-1:0]    pe_load_weight,
    output logic                pe_weight_in,
    output logic                pe_go,
    output logic                pe_data_in,
    output logic                pe_idx_enable,
    output logic [ADDR_W-1:0]   pe_write_addr,
    output logic [3:0]          pe_idx,
    input  logic [KW*KW-1:0]    pe_negative_flag,
    output logic                omem_we,
    output logic [ADDR_W-1:0]   omem_addr,
    output logic                omem_wr_data
);
    localparam int K     = KW * KW;
    localparam int OUT_W = IMG_W - KW + 1;
    localparam int CW    = $clog2(K + 1);
    localparam int KRW   = $clog2(KW + 1);

    localparam logic [CW-1:0]     LAST_STEP = CW'(K);
    localparam logic [CW-1:0]     HALF      = CW'((K - 1) / 2);
    localparam logic [KRW-1:0]    KC_LAST   = KRW'(KW - 1);
    localparam logic [ADDR_W-1:0] RC_LAST   = ADDR_W'(OUT_W - 1);
    localparam logic [K-1:0]      ONE_K     = K'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_STREAM,
        S_EVAL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      step;
    logic [CW-1:0]      pop;
    logic [CW-1:0]      cnt;
    logic [KRW-1:0]     kr, kc;
    logic [ADDR_W-1:0]  row, col, pix_addr;
    logic [ADDR_W-1:0]  img_off;
    logic               last_step, last_pix;

    assign last_step = (step == LAST_STEP);
    assign last_pix  = (row == RC_LAST) && (col == RC_LAST);
    // kr/kc walk the window taps in row-major order alongside step.
    assign img_off   = (row + ADDR_W'(kr)) * ADDR_W'(IMG_W) + col + ADDR_W'(kc);

    always_comb begin
        pop = '0;
        for (int j = 0; j < K; j++) begin
            pop = pop + CW'(pe_negative_flag[j]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            step     <= '0;
            kr       <= '0;
            kc       <= '0;
            row      <= '0;
            col      <= '0;
            pix_addr <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    step     <= '0;
                    kr       <= '0;
                    kc       <= '0;
                    row      <= '0;
                    col      <= '0;
                    pix_addr <= '0;
                end
                S_WLOAD: step <= last_step ? '0 : step + CW'(1);
                S_STREAM: begin
                    if (last_step) begin
                        step <= '0;
                        kr   <= '0;
                        kc   <= '0;
                    end else begin
                        step <= step + CW'(1);
                        if (kc == KC_LAST) begin
                            kc <= '0;
                            kr <= kr + KRW'(1);
                        end else begin
                            kc <= kc + KRW'(1);
                        end
                    end
                end
                S_EVAL: cnt <= pop;
                S_WRITE: begin
                    pix_addr <= pix_addr + ADDR_W'(1);
                    if (col == RC_LAST) begin
                        col <= '0;
                        row <= row + ADDR_W'(1);
                    end else begin
                        col <= col + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b0;
        done           = 1'b0;
        wmem_addr      = '0;
        imem_addr      = '0;
        pe_load_weight = '0;
        pe_weight_in   = 1'b0;
        pe_go          = 1'b0;
        pe_data_in     = 1'b0;
        pe_idx_enable  = 1'b0;
        pe_write_addr  = '0;
        pe_idx         = '0;
        omem_we        = 1'b0;
        omem_addr      = '0;
        omem_wr_data   = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_WLOAD;
            S_WLOAD: begin
                busy = 1'b1;
                if (!last_step) wmem_addr = ADDR_W'(step);
                // Tap i-1 goes to PE[K-i], so tap 0 ends up where its data settles.
                if (step != '0) begin
                    pe_load_weight = ONE_K << (LAST_STEP - step);
                    pe_weight_in   = wmem_rd_data;
                end
                if (last_step) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                busy = 1'b1;
                if (!last_step) imem_addr = img_off;
                if (step != '0) begin
                    pe_go      = 1'b1;
                    pe_data_in = imem_rd_data;
                end
                if (last_step) begin
                    pe_idx_enable = 1'b1;
                    pe_write_addr = pix_addr;
                    pe_idx        = 4'(K - 1);
                    state_nxt     = S_EVAL;
                end
            end
            S_EVAL: begin
                busy      = 1'b1;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                busy         = 1'b1;
                omem_we      = 1'b1;
                omem_addr    = pix_addr;
                omem_wr_data = (cnt <= HALF);
                state_nxt    = last_pix ? S_DONE : S_STREAM;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_bconv_seq_ctrl.sv
// Bench for bconv_seq_ctrl: behavioural memories and PE chain, random jobs scored against a
// direct window-convolution reference model.
module tb_bconv_seq_ctrl;
    localparam int KW       = 3;
    localparam int IMG_W    = 16;
    localparam int ADDR_W   = 12;
    localparam int K        = KW * KW;
    localparam int OUT_W    = IMG_W - KW + 1;
    localparam int NPIX     = IMG_W * IMG_W;
    localparam int BUSY_CYC = (K + 1) + OUT_W * OUT_W * (K + 3);

    logic                clock = 1'b0;
    logic                reset, start;
    logic                busy, done;
    logic [ADDR_W-1:0]   wmem_addr, imem_addr, pe_write_addr, omem_addr;
    logic                wmem_rd_data, imem_rd_data;
    logic [K-1:0]        pe_load_weight, pe_negative_flag;
    logic                pe_weight_in, pe_go, pe_data_in, pe_idx_enable;
    logic [3:0]          pe_idx;
    logic                omem_we, omem_wr_data;

    logic [K-1:0]        wmem_bits;
    logic                img [NPIX];
    logic [K-1:0]        pe_w, pe_d, model_flags, force_flags;
    logic                force_en;
    logic                outs_any;

    logic [ADDR_W:0]     exp_q[$];
    int                  vectors, miscompares;

    bconv_seq_ctrl #(.KW(KW), .IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .wmem_addr(wmem_addr), .wmem_rd_data(wmem_rd_data),
        .imem_addr(imem_addr), .imem_rd_data(imem_rd_data),
        .pe_load_weight(pe_load_weight), .pe_weight_in(pe_weight_in), .pe_go(pe_go),
        .pe_data_in(pe_data_in), .pe_idx_enable(pe_idx_enable), .pe_write_addr(pe_write_addr),
        .pe_idx(pe_idx), .pe_negative_flag(pe_negative_flag),
        .omem_we(omem_we), .omem_addr(omem_addr), .omem_wr_data(omem_wr_data)
    );

    always #5 clock = ~clock;

    // Synchronous memories with one cycle of read latency.
    always @(posedge clock) begin
        wmem_rd_data <= (int'(wmem_addr) < K) ? wmem_bits[int'(wmem_addr)] : 1'b0;
        imem_rd_data <= (int'(imem_addr) < NPIX) ? img[int'(imem_addr)] : 1'b0;
    end

    // Behavioural PE chain: per-PE weight latch, data shifting from PE[0] toward PE[K-1].
    always @(posedge clock) begin
        for (int j = 0; j < K; j++) begin
            if (pe_load_weight[j]) pe_w[j] <= pe_weight_in;
        end
        if (pe_go) pe_d <= {pe_d[K-2:0], pe_data_in};
    end

    assign model_flags      = pe_w ^ pe_d;
    assign pe_negative_flag = force_en ? force_flags : model_flags;
    assign outs_any = busy | done | (|wmem_addr) | (|imem_addr) | (|pe_load_weight) | pe_weight_in
                    | pe_go | pe_data_in | pe_idx_enable | (|pe_write_addr) | (|pe_idx)
                    | omem_we | (|omem_addr) | omem_wr_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [K-1:0] pick(input int n);
        logic [K-1:0] v;
        v = '0;
        while ($countones(v) < n) v[$urandom_range(K - 1, 0)] = 1'b1;
        return v;
    endfunction

    // mode 0: random weights and image; 1: all ones; 2: fixed weight pattern, random image.
    task automatic fill(input int mode);
        logic [K-1:0] patt;
        patt = 9'b111001101;
        for (int p = 0; p < NPIX; p++) img[p] = (mode == 1) ? 1'b1 : 1'($urandom_range(1, 0));
        for (int t = 0; t < K; t++) begin
            case (mode)
                1:       wmem_bits[t] = 1'b1;
                2:       wmem_bits[t] = patt[t];
                default: wmem_bits[t] = 1'($urandom_range(1, 0));
            endcase
        end
    endtask

    // Each output pixel: count taps whose weight sign disagrees with the image bit; positive if
    // at most half disagree.
    task automatic build_expect();
        int n;
        exp_q.delete();
        for (int r = 0; r < OUT_W; r++) begin
            for (int c = 0; c < OUT_W; c++) begin
                n = 0;
                if (force_en) n = $countones(force_flags);
                else begin
                    for (int t = 0; t < K; t++) begin
                        if (wmem_bits[t] != img[(r + t / KW) * IMG_W + c + t % KW]) n++;
                    end
                end
                exp_q.push_back({ADDR_W'(r * OUT_W + c), 1'(n <= (K - 1) / 2)});
            end
        end
    endtask

    task automatic score_write();
        logic [ADDR_W:0] e;
        if (exp_q.size() == 0) check("extra_write", {omem_addr, omem_wr_data}, 32'hffff_ffff);
        else begin
            e = exp_q.pop_front();
            check("omem_write", {omem_addr, omem_wr_data}, e);
        end
    endtask

    task automatic run_job(input bit wl_chk, input bit mid_start);
        int busy_cnt, done_cnt, pix_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        pix_cnt  = 0;
        build_expect();
        @(negedge clock);
        start = 1'b1;
        for (int c = 1; c <= BUSY_CYC + 8; c++) begin
            @(negedge clock);
            start = mid_start && (c % 487 == 0);
            if (wl_chk && c <= K + 1) begin
                if (c - 1 < K) check("wmem_addr", wmem_addr, c - 1);
                if (c >= 2) begin
                    check("pe_load_weight", pe_load_weight, 1 << (K - (c - 1)));
                    check("pe_weight_in", pe_weight_in, wmem_bits[c - 2]);
                end
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) check("done_cycle", c, BUSY_CYC + 1);
                if (mid_start) start = 1'b1;
            end
            if (pe_idx_enable) begin
                check("pe_write_addr", pe_write_addr, pix_cnt);
                check("pe_idx", pe_idx, K - 1);
                pix_cnt++;
            end
            if (omem_we) score_write();
        end
        start = 1'b0;
        check("busy_cycles", busy_cnt, BUSY_CYC);
        check("done_pulses", done_cnt, 1);
        check("writes_left", exp_q.size(), 0);
    endtask

    task automatic abort_job();
        int wr, quiet;
        wr = 0;
        quiet = 0;
        build_expect();
        @(negedge clock);
        start = 1'b1;
        for (int c = 0; c < 200 && wr < 5; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (omem_we) begin
                score_write();
                wr++;
            end
        end
        check("abort_writes_seen", wr, 5);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_outs", outs_any, 0);
        check("abort_busy", busy, 0);
        reset = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (busy || omem_we || done) quiet++;
        end
        check("abort_quiet", quiet, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b1;
        force_en    = 1'b0;
        force_flags = '0;
        wmem_bits   = '0;
        for (int p = 0; p < NPIX; p++) img[p] = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outs", outs_any, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        start = 1'b0;

        fill(2);
        run_job(1'b1, 1'b0);
        fill(1);
        run_job(1'b0, 1'b0);

        fill(0);
        force_en    = 1'b1;
        force_flags = pick((K - 1) / 2);
        run_job(1'b0, 1'b0);
        force_flags = pick((K + 1) / 2);
        run_job(1'b0, 1'b0);
        force_en = 1'b0;

        fill(0);
        run_job(1'b0, 1'b1);
        fill(0);
        abort_job();
        fill(0);
        run_job(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
